// File: rtl/gate_sweep_controller.sv
// Self-test sequencer for the 7-function gate unit: steps every gate through all
// a/b combinations, captures y into a truth table and checks it against a golden table.
module gate_sweep_controller #(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  input  logic               start,
  input  logic               mode,
  input  logic               step,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               y_in,
  output logic               a_out,
  output logic               b_out,
  output logic [2:0]         sel_out,
  output logic               tt_valid,
  output logic [2:0]         tt_sel,
  output logic [3:0]         tt_row,
  output logic [6:0]         fail_mask,
  output logic               busy,
  output logic               done,
  output logic               pass
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DRIVE  = 3'd1,
    SAMPLE = 3'd2,
    REPORT = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t             state_r;
  logic [1:0]         ab_r;
  logic [2:0]         sel_r;
  logic [DWELL_W-1:0] cnt_r;
  logic [3:0]         row_r;
  logic [3:0]         row_s;

  // Expected truth table per gate, bit index {a,b}
  function automatic logic [3:0] golden(input logic [2:0] g);
    logic [3:0] t;
    case (g)
      3'd0:    t = 4'b1000;
      3'd1:    t = 4'b1110;
      3'd2:    t = 4'b0011;
      3'd3:    t = 4'b0111;
      3'd4:    t = 4'b0001;
      3'd5:    t = 4'b0110;
      3'd6:    t = 4'b1001;
      default: t = 4'b0000;
    endcase
    return t;
  endfunction

  // ab_r and sel_r are zeroed whenever the sweep is not running, so these stay registered
  assign a_out   = ab_r[1];
  assign b_out   = ab_r[0];
  assign sel_out = sel_r;

  // Row register with the current sample merged in
  always_comb begin
    row_s        = row_r;
    row_s[ab_r]  = y_in;
  end

  // Sweep FSM and all registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      ab_r      <= 2'b00;
      sel_r     <= 3'd0;
      cnt_r     <= {DWELL_W{1'b0}};
      row_r     <= 4'b0000;
      tt_valid  <= 1'b0;
      tt_sel    <= 3'd0;
      tt_row    <= 4'b0000;
      fail_mask <= 7'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
    end else if (ena) begin
      tt_valid <= 1'b0;
      case (state_r)
        IDLE, DONE: begin
          if (start) begin
            state_r   <= DRIVE;
            ab_r      <= 2'b00;
            sel_r     <= 3'd0;
            cnt_r     <= dwell;
            fail_mask <= 7'd0;
            busy      <= 1'b1;
            done      <= 1'b0;
            pass      <= 1'b0;
          end
        end
        DRIVE: begin
          // Manual mode leaves the counter untouched so a later switch to auto resumes cleanly
          if (mode) begin
            if (step) begin
              state_r <= SAMPLE;
            end
          end else if (cnt_r == {DWELL_W{1'b0}}) begin
            state_r <= SAMPLE;
          end else begin
            cnt_r <= cnt_r - {{(DWELL_W-1){1'b0}}, 1'b1};
          end
        end
        SAMPLE: begin
          row_r <= row_s;
          if (ab_r == 2'b11) begin
            state_r  <= REPORT;
            tt_valid <= 1'b1;
            tt_sel   <= sel_r;
            tt_row   <= row_s;
            if (row_s != golden(sel_r)) begin
              fail_mask[sel_r] <= 1'b1;
            end
          end else begin
            ab_r    <= ab_r + 2'b01;
            cnt_r   <= dwell;
            state_r <= DRIVE;
          end
        end
        REPORT: begin
          ab_r  <= 2'b00;
          cnt_r <= dwell;
          if (sel_r == 3'd6) begin
            state_r <= DONE;
            sel_r   <= 3'd0;
            busy    <= 1'b0;
            done    <= 1'b1;
            pass    <= (fail_mask == 7'd0);
          end else begin
            sel_r   <= sel_r + 3'd1;
            state_r <= DRIVE;
          end
        end
        default: begin
          state_r <= IDLE;
          ab_r    <= 2'b00;
          sel_r   <= 3'd0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
